// File: rtl/x_ctrl.sv
// x_ctrl: single-issue accumulator controller (regA/regB/carry/pc) with same-cycle decode and data-bus requests.
// Branch opcodes 12-15 are only built when `XCTRL_BRANCH_EN is defined; otherwise they execute as NOPs.
module x_ctrl #(
  parameter int DATA_W     = 32,
  parameter int INSTR_W    = 32,
  parameter int OPCODESZ   = 4,
  parameter int IMM_W      = 16,
  parameter int IADDR_W    = 10,
  parameter int INT_ADDR_W = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INSTR_W-1:0]    instruction,
  output logic [IADDR_W-1:0]    pc,
  output logic                  rw_req,
  output logic                  rw_rnw,
  output logic [INT_ADDR_W-1:0] rw_addr,
  input  logic [DATA_W-1:0]     data_to_rd,
  output logic [DATA_W-1:0]     data_to_wr,
  input  logic                  regB_req,
  output logic [DATA_W-1:0]     regB,
  output logic [DATA_W-1:0]     cs
);
  localparam logic [OPCODESZ-1:0] OP_ADDI  = OPCODESZ'(0);
  localparam logic [OPCODESZ-1:0] OP_ADD   = OPCODESZ'(1);
  localparam logic [OPCODESZ-1:0] OP_SUB   = OPCODESZ'(2);
  localparam logic [OPCODESZ-1:0] OP_SHFT  = OPCODESZ'(3);
  localparam logic [OPCODESZ-1:0] OP_AND   = OPCODESZ'(4);
  localparam logic [OPCODESZ-1:0] OP_XOR   = OPCODESZ'(5);
  localparam logic [OPCODESZ-1:0] OP_LDI   = OPCODESZ'(6);
  localparam logic [OPCODESZ-1:0] OP_LDIH  = OPCODESZ'(7);
  localparam logic [OPCODESZ-1:0] OP_RDW   = OPCODESZ'(8);
  localparam logic [OPCODESZ-1:0] OP_WRW   = OPCODESZ'(9);
  localparam logic [OPCODESZ-1:0] OP_RDWB  = OPCODESZ'(10);
  localparam logic [OPCODESZ-1:0] OP_WRWB  = OPCODESZ'(11);
`ifdef XCTRL_BRANCH_EN
  localparam logic [OPCODESZ-1:0] OP_BEQI  = OPCODESZ'(12);
  localparam logic [OPCODESZ-1:0] OP_BEQ   = OPCODESZ'(13);
  localparam logic [OPCODESZ-1:0] OP_BNEQI = OPCODESZ'(14);
  localparam logic [OPCODESZ-1:0] OP_BNEQ  = OPCODESZ'(15);
`endif
  logic [DATA_W-1:0]     rega_q, rega_d, regb_q, regb_d;
  logic                  carry_q, carry_d;
  logic [IADDR_W-1:0]    pc_q, pc_d;
  logic [OPCODESZ-1:0]   op;
  logic [IMM_W-1:0]      imm;
  logic [DATA_W-1:0]     sext, ea_b, addend;
  logic [INT_ADDR_W-1:0] ea;
  logic [DATA_W:0]       add_res, sub_res;
  logic                  mem_op, wr_op, zero;
  logic                  unused_bits;
  assign op          = instruction[INSTR_W-1 -: OPCODESZ];
  assign imm         = instruction[IMM_W-1:0];
  assign sext        = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign ea_b        = regb_q + sext;
  assign ea          = (op == OP_RDWB || op == OP_WRWB) ? ea_b[INT_ADDR_W-1:0] : imm[INT_ADDR_W-1:0];
  assign mem_op      = op inside {OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_RDW, OP_WRW, OP_RDWB, OP_WRWB};
  assign wr_op       = op == OP_WRW || op == OP_WRWB;
  assign zero        = rega_q == '0;
  assign addend      = op == OP_ADDI ? sext : data_to_rd;
  assign add_res     = {1'b0, rega_q} + {1'b0, addend};
  assign sub_res     = {1'b0, rega_q} - {1'b0, data_to_rd};
  assign unused_bits = ^{instruction[INSTR_W-OPCODESZ-1:IMM_W], ea_b[DATA_W-1:INT_ADDR_W]};
  assign rw_req      = mem_op & ~rst;
  assign rw_rnw      = ~wr_op;
  assign rw_addr     = ea;
  assign pc          = pc_q;
  assign data_to_wr  = rega_q;
  assign regB        = regb_q;
  assign cs          = {{(DATA_W-3){1'b0}}, rega_q[DATA_W-1], zero, carry_q};
  always_comb begin
    rega_d  = rega_q;
    carry_d = carry_q;
    case (op)
      OP_ADDI, OP_ADD: {carry_d, rega_d} = add_res;
      OP_SUB:          {carry_d, rega_d} = sub_res;
      OP_SHFT:         rega_d = imm[IMM_W-1] ? {rega_q[DATA_W-1], rega_q[DATA_W-1:1]} : {rega_q[DATA_W-2:0], 1'b0};
      OP_AND:          rega_d = rega_q & data_to_rd;
      OP_XOR:          rega_d = rega_q ^ data_to_rd;
      OP_LDI:          rega_d = sext;
      OP_LDIH:         rega_d = {imm[15:0], rega_q[DATA_W-17:0]};
      OP_RDW, OP_RDWB: rega_d = data_to_rd;
      default:         ;
    endcase
  end
  // The external strobe takes priority over the write-to-all-ones shadow load.
  assign regb_d = regB_req ? data_to_rd : (wr_op && &ea) ? rega_q : regb_q;
`ifdef XCTRL_BRANCH_EN
  logic                br_take;
  logic [IADDR_W-1:0]  br_tgt;
  assign br_take = ((op == OP_BEQI || op == OP_BEQ) && zero) || ((op == OP_BNEQI || op == OP_BNEQ) && !zero);
  assign br_tgt  = (op == OP_BEQ || op == OP_BNEQ) ? regb_q[IADDR_W-1:0] : imm[IADDR_W-1:0];
  assign pc_d    = br_take ? br_tgt : pc_q + IADDR_W'(1);
`else
  assign pc_d    = pc_q + IADDR_W'(1);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      rega_q  <= '0;
      regb_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      carry_q <= carry_d;
    end
  end
endmodule

// File: tb/tb_x_ctrl.sv
// tb_x_ctrl: directed self-checking bench for x_ctrl; branch expectations follow `XCTRL_BRANCH_EN.
module tb_x_ctrl;
`ifdef XCTRL_BRANCH_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif
  localparam logic [3:0] ADDI = 4'd0, ADD = 4'd1, SUB = 4'd2, SHFT = 4'd3, AND = 4'd4, XOR = 4'd5;
  localparam logic [3:0] LDI = 4'd6, LDIH = 4'd7, RDW = 4'd8, WRW = 4'd9, RDWB = 4'd10, WRWB = 4'd11;
  localparam logic [3:0] BEQI = 4'd12, BEQ = 4'd13, BNEQI = 4'd14, BNEQ = 4'd15;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic [9:0]  pc;
  logic        rw_req, rw_rnw;
  logic [12:0] rw_addr;
  logic [31:0] data_to_rd, data_to_wr, regB, cs;
  logic        regB_req;
  logic [9:0]  exp_pc;
  int          checks = 0;
  int          errors = 0;
  x_ctrl dut (
    .clk(clk), .rst(rst), .instruction(instruction), .pc(pc),
    .rw_req(rw_req), .rw_rnw(rw_rnw), .rw_addr(rw_addr),
    .data_to_rd(data_to_rd), .data_to_wr(data_to_wr),
    .regB_req(regB_req), .regB(regB), .cs(cs)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  // Middle instruction bits are non-zero on purpose: the design must ignore them.
  task automatic drive(input logic [3:0] op, input logic [15:0] imm, input logic [31:0] rd, input logic breq);
    instruction = {op, 12'hABC, imm};
    data_to_rd  = rd;
    regB_req    = breq;
    #1;
  endtask
  task automatic tick(input bit br, input logic [9:0] tgt);
    @(posedge clk);
    @(negedge clk);
    exp_pc = rst ? 10'd0 : br ? tgt : exp_pc + 10'd1;
    chk("pc", 32'(pc), 32'(exp_pc));
  endtask
  task automatic bus(input string tag, input logic req, input logic rnw, input logic [12:0] addr);
    chk({tag, "_req"}, 32'(rw_req), 32'(req));
    chk({tag, "_rnw"}, 32'(rw_rnw), 32'(rnw));
    chk({tag, "_addr"}, 32'(rw_addr), 32'(addr));
  endtask
  initial begin
    exp_pc = '0;
    rst    = 1'b1;
    drive(RDW, 16'h0004, 32'h0, 1'b0);
    chk("rst_req", 32'(rw_req), 32'h0);
    tick(1'b0, '0);
    tick(1'b0, '0);
    chk("rst_regA", data_to_wr, 32'h0);
    chk("rst_regB", regB, 32'h0);
    chk("rst_cs", cs, 32'h2);
    rst = 1'b0;
    drive(LDI, 16'd3, 32'h0, 1'b0);
    chk("ldi_req", 32'(rw_req), 32'h0);
    tick(1'b0, '0);
    chk("ldi_regA", data_to_wr, 32'd3);
    drive(WRW, 16'd6, 32'h0, 1'b0);
    bus("wrw", 1'b1, 1'b0, 13'd6);
    chk("wrw_data", data_to_wr, 32'd3);
    tick(1'b0, '0);
    drive(RDW, 16'd0, 32'hA5, 1'b0);
    bus("rdw", 1'b1, 1'b1, 13'd0);
    tick(1'b0, '0);
    chk("rdw_regA", data_to_wr, 32'hA5);
    drive(ADD, 16'd1, 32'hA5, 1'b0);
    bus("add", 1'b1, 1'b1, 13'd1);
    tick(1'b0, '0);
    chk("add_regA", data_to_wr, 32'h14A);
    chk("add_cs", cs, 32'h0);
    drive(LDI, 16'hFFFF, 32'h0, 1'b0);
    tick(1'b0, '0);
    chk("ldim1_regA", data_to_wr, 32'hFFFF_FFFF);
    chk("ldim1_cs", cs, 32'h4);
    drive(ADDI, 16'd1, 32'h0, 1'b0);
    tick(1'b0, '0);
    chk("addi_regA", data_to_wr, 32'h0);
    chk("addi_cs", cs, 32'h3);
    drive(SUB, 16'd5, 32'd1, 1'b0);
    bus("sub", 1'b1, 1'b1, 13'd5);
    tick(1'b0, '0);
    chk("sub_regA", data_to_wr, 32'hFFFF_FFFF);
    chk("sub_cs", cs, 32'h5);
    drive(LDI, 16'd7, 32'h10, 1'b1);
    tick(1'b0, '0);
    chk("breq_regB", regB, 32'h10);
    chk("carry_hold_cs", cs, 32'h1);
    drive(RDWB, 16'd2, 32'd7, 1'b0);
    bus("rdwb", 1'b1, 1'b1, 13'h12);
    tick(1'b0, '0);
    chk("rdwb_regA", data_to_wr, 32'd7);
    drive(WRW, 16'h1FFF, 32'h0, 1'b0);
    bus("wrw_ff", 1'b1, 1'b0, 13'h1FFF);
    chk("wrw_ff_data", data_to_wr, 32'd7);
    tick(1'b0, '0);
    chk("wrw_ff_regB", regB, 32'd7);
    drive(WRWB, 16'h1FF8, 32'h99, 1'b1);
    bus("wrwb_ff", 1'b1, 1'b0, 13'h1FFF);
    tick(1'b0, '0);
    chk("prio_regB", regB, 32'h99);
    drive(RDWB, 16'hFFFF, 32'h8000_0000, 1'b0);
    bus("rdwb_neg", 1'b1, 1'b1, 13'h98);
    tick(1'b0, '0);
    chk("rdwb_neg_cs", cs, 32'h5);
    drive(SHFT, 16'h8000, 32'h0, 1'b0);
    tick(1'b0, '0);
    chk("asr_regA", data_to_wr, 32'hC000_0000);
    drive(SHFT, 16'h0001, 32'h0, 1'b0);
    bus("shft", 1'b0, 1'b1, 13'h1);
    tick(1'b0, '0);
    chk("shl_regA", data_to_wr, 32'h8000_0000);
    drive(SHFT, 16'h0000, 32'h0, 1'b0);
    tick(1'b0, '0);
    chk("shl0_cs", cs, 32'h3);
    drive(LDI, 16'h0F0F, 32'h0, 1'b0);
    tick(1'b0, '0);
    drive(AND, 16'd3, 32'hFF, 1'b0);
    tick(1'b0, '0);
    chk("and_regA", data_to_wr, 32'h0F);
    drive(XOR, 16'd4, 32'hF0, 1'b0);
    tick(1'b0, '0);
    chk("xor_regA", data_to_wr, 32'hFF);
    drive(LDIH, 16'hABCD, 32'h0, 1'b0);
    tick(1'b0, '0);
    chk("ldih_regA", data_to_wr, 32'hABCD_00FF);
    drive(SUB, 16'd8, 32'hABCD_0100, 1'b0);
    tick(1'b0, '0);
    chk("sub2_regA", data_to_wr, 32'hFFFF_FFFF);
    chk("sub2_cs", cs, 32'h5);
    drive(ADD, 16'd9, 32'd1, 1'b0);
    tick(1'b0, '0);
    chk("add2_cs", cs, 32'h3);
    drive(BEQI, 16'h0020, 32'h0, 1'b0);
    bus("beqi", 1'b0, 1'b1, 13'h20);
    tick(BR, 10'h20);
    chk("beqi_regA", data_to_wr, 32'h0);
    drive(LDI, 16'd5, 32'h0, 1'b0);
    tick(1'b0, '0);
    drive(BEQI, 16'h0020, 32'h0, 1'b0);
    tick(1'b0, '0);
    drive(BEQ, 16'h0000, 32'h0, 1'b0);
    tick(1'b0, '0);
    drive(BNEQ, 16'h0000, 32'h0, 1'b0);
    tick(BR, 10'h099);
    chk("bneq_regA", data_to_wr, 32'd5);
    drive(BNEQI, 16'hF3FF, 32'h0, 1'b0);
    tick(BR, 10'h3FF);
    drive(LDI, 16'd5, 32'h0, 1'b0);
    tick(1'b0, '0);
    drive(WRW, 16'd1, 32'h0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_req0", 32'(rw_req), 32'h0);
    tick(1'b0, '0);
    chk("midrst_regA", data_to_wr, 32'h0);
    chk("midrst_regB", regB, 32'h0);
    chk("midrst_cs", cs, 32'h2);
    chk("midrst_req1", 32'(rw_req), 32'h0);
    rst = 1'b0;
    #1;
    chk("postrst_req", 32'(rw_req), 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/x_ctrl.md
Name: x_ctrl

Overview:
- Single-issue accumulator controller: fetches one instruction per clock from external instruction memory via `pc`, executes it in the same cycle, and issues data-bus read/write requests.
- Holds accumulator regA, pointer register regB, a carry flag and the program counter.
- Sits between the instruction ROM and the internal data bus of the processing engine; exports regB and a control/status word.

Parameters:
- DATA_W, 32: data/accumulator width.
- INSTR_W, 32: instruction width; opcode in [INSTR_W-1 -: OPCODESZ], immediate in [IMM_W-1:0], middle bits ignored.
- OPCODESZ, 4: opcode width.
- IMM_W, 16: immediate width.
- IADDR_W, 10: program counter width.
- INT_ADDR_W, 13: data-bus address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instruction  in  INSTR_W  instruction at current pc.
- pc  out  IADDR_W  program counter (registered).
- rw_req  out  1  data-bus request (combinational).
- rw_rnw  out  1  1 = read, 0 = write (combinational).
- rw_addr  out  INT_ADDR_W  data-bus address (combinational).
- data_to_rd  in  DATA_W  read data, valid in the same cycle as the request.
- data_to_wr  out  DATA_W  write data, always equal to regA.
- regB_req  in  1  external load strobe for regB.
- regB  out  DATA_W  pointer register.
- cs  out  DATA_W  status word: bit0 carry, bit1 regA==0, bit2 regA[DATA_W-1], other bits 0.

Behaviour:
- Reset (rst=1 at a clock edge): pc, regA, regB and carry all become 0. While rst is high, rw_req=0.
- pc increments by 1 each cycle (wraps at 2^IADDR_W) unless a branch is taken.
- Fetch/execute latency is zero: the instruction is decoded combinationally and its result is visible in regA, regB and carry after the next edge.
- sext(imm) = sign-extended immediate to DATA_W. Effective address EA = imm[INT_ADDR_W-1:0], or (regB+sext(imm))[INT_ADDR_W-1:0] for the B-indexed forms.
- Opcodes:
  - 0 ADDI: regA += sext(imm); carry = carry-out.
  - 1 ADD: read EA; regA += data_to_rd; carry = carry-out.
  - 2 SUB: read EA; regA -= data_to_rd; carry = borrow.
  - 3 SHFT: imm negative → arithmetic right shift of regA by 1; otherwise left shift by 1, zero fill.
  - 4 AND: read EA; regA &= data_to_rd.
  - 5 XOR: read EA; regA ^= data_to_rd.
  - 6 LDI: regA = sext(imm).
  - 7 LDIH: regA[DATA_W-1:DATA_W-16] = imm[15:0]; low bits kept.
  - 8 RDW: read EA; regA = data_to_rd.
  - 9 WRW: write EA with data_to_wr = regA.
  - 10 RDWB: read, B-indexed; regA = data_to_rd.
  - 11 WRWB: write, B-indexed.
  - 12 BEQI: if regA==0, pc = imm.
  - 13 BEQ: if regA==0, pc = regB.
  - 14 BNEQI: if regA!=0, pc = imm.
  - 15 BNEQ: if regA!=0, pc = regB.
- Memory ops (1,2,4,5,8–11) assert rw_req=1, with rw_rnw=0 only for 9 and 11. All other ops drive rw_req=0, rw_rnw=1, rw_addr=EA.
- Carry is modified only by ADDI/ADD/SUB and is held otherwise.
- regB load:
  - Source: regB_req=1 loads regB = data_to_rd at the edge.
  - Write address: a WRW/WRWB to address all-ones of INT_ADDR_W also loads regB = regA; that write is still presented on the bus.
  - Simultaneous events: if regB_req and such a write occur in the same cycle, regB_req wins.
- Branch targets are truncated to IADDR_W. A taken branch overrides the increment.

Optional Feature:
XCTRL_BRANCH_EN
- Defined: opcodes 12–15 behave as above.
- Undefined: opcodes 12–15 are NOPs (pc increments, no state change, rw_req=0) and the branch logic is not synthesized.

Test Plan:
- Reset, then LDI 3; WRW 6 → at the WRW cycle rw_req=1, rw_rnw=0, rw_addr=6, data_to_wr=3; pc advances 0,1,2,…
- RDW 0 with data_to_rd=0xA5; ADD 1 with data_to_rd=0xA5 → regA=0xA5 then 0x14A; rw_req=1, rw_rnw=1, rw_addr=1 during the ADD; carry=0.
- LDI -1 (0xFFFF); ADDI 1 → regA=0, carry=1, cs=0x3; then SUB with data_to_rd=1 → regA=0xFFFFFFFF, carry=1 (borrow), cs bit2=1.
- regB_req=1 with data_to_rd=0x10; RDWB imm 2 → rw_addr=0x12; WRW to 0x1FFF with regA=7 → regB=7.
- BEQI 0x20 with regA=0 → pc=0x20 next cycle; with regA≠0 → pc+1. With XCTRL_BRANCH_EN undefined → always pc+1.
- Assert rst mid-program while regA≠0 and pc≠0 → after the edge pc=0, regA=0, regB=0, cs=0x2, rw_req=0 while rst is held.
